// File: rtl/lc_transition_ctrl.sv
// Life-cycle transition requester: fetches the unlock token for a target state from
// lc_memory, compares it with the user token, and advances lc_state or counts failures.
`ifndef LC_MEMORY_WIDTH
`define LC_MEMORY_WIDTH 256
`endif

module lc_transition_ctrl #(
    parameter int WIDTH     = `LC_MEMORY_WIDTH,
    parameter int LENGTH    = 6,
    parameter int TIMEOUT   = 8,
    parameter int MAX_FAILS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic [$clog2(LENGTH)-1:0] target_state,
    input  logic [WIDTH-1:0]          token_in,
    output logic                      mem_rd_en,
    output logic [$clog2(LENGTH)-1:0] mem_addr,
    input  logic [WIDTH-1:0]          mem_rdData,
    input  logic                      mem_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      grant,
    output logic [1:0]                err,
    output logic [$clog2(LENGTH)-1:0] lc_state,
    output logic                      locked
);

    localparam int IW = $clog2(LENGTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [IW:0]   LEN_W  = (IW + 1)'(LENGTH);
    localparam logic [TW-1:0] TO_W   = TW'(TIMEOUT);
    localparam logic [FW-1:0] MAXF_W = FW'(MAX_FAILS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tok_q, tok_d;
    logic [IW-1:0]    tgt_q, tgt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [FW-1:0]    fail_q, fail_d;
    logic             rd_en_d, busy_d, done_d, grant_d, locked_d;
    logic [1:0]       err_d;
    logic [IW-1:0]    addr_d, lc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tok_q     <= '0;
            tgt_q     <= '0;
            tcnt_q    <= '0;
            fail_q    <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            grant     <= 1'b0;
            err       <= '0;
            lc_state  <= '0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tok_q     <= tok_d;
            tgt_q     <= tgt_d;
            tcnt_q    <= tcnt_d;
            fail_q    <= fail_d;
            mem_rd_en <= rd_en_d;
            mem_addr  <= addr_d;
            busy      <= busy_d;
            done      <= done_d;
            grant     <= grant_d;
            err       <= err_d;
            lc_state  <= lc_d;
            locked    <= locked_d;
        end
    end

    // Next values are the registered outputs for the state being entered.
    always_comb begin
        state_d  = state_q;
        tok_d    = tok_q;
        tgt_d    = tgt_q;
        tcnt_d   = tcnt_q;
        fail_d   = fail_q;
        rd_en_d  = 1'b0;
        addr_d   = mem_addr;
        busy_d   = busy;
        done_d   = 1'b0;
        grant_d  = grant;
        err_d    = err;
        lc_d     = lc_state;
        locked_d = locked;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    grant_d = 1'b0;
                    if (locked || (target_state <= lc_state) ||
                        ({1'b0, target_state} >= LEN_W)) begin
                        err_d   = 2'd1;
                        done_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 2'd0;
                        tok_d   = token_in;
                        tgt_d   = target_state;
                        busy_d  = 1'b1;
                        rd_en_d = 1'b1;
                        addr_d  = target_state;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    if (mem_rdData == tok_q) begin
                        lc_d    = tgt_q;
                        fail_d  = '0;
                        grant_d = 1'b1;
                        err_d   = 2'd0;
                    end else begin
                        if (fail_q < MAXF_W) begin
                            fail_d = fail_q + 1'b1;
                        end
                        if (fail_d == MAXF_W) begin
                            locked_d = 1'b1;
                        end
                        err_d = 2'd2;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RESP;
                end else if (tcnt_q == TO_W) begin
                    err_d   = 2'd3;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lc_transition_ctrl.sv
// Directed self-checking bench for lc_transition_ctrl with a 1-cycle-latency memory model.
module tb_lc_transition_ctrl;

    localparam int WIDTH   = 256;
    localparam int LENGTH  = 6;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req = 1'b0;
    logic [2:0]       target_state = '0;
    logic [WIDTH-1:0] token_in = '0;
    logic             mem_rd_en;
    logic [2:0]       mem_addr;
    logic [WIDTH-1:0] mem_rdData = '0;
    logic             mem_valid = 1'b0;
    logic             busy, done, grant, locked;
    logic [1:0]       err;
    logic [2:0]       lc_state;

    logic [WIDTH-1:0] mem [LENGTH];
    logic             withhold = 1'b0;

    int checks = 0;
    int failures = 0;

    // Per-request observations
    int         rd_first, rd_cnt, done_cyc, busy1;
    logic [2:0] addr_seen;
    logic       grant_seen;
    logic [1:0] err_seen;

    localparam logic [WIDTH-1:0] TOK_A = {8{32'h33a344a3}};
    localparam logic [WIDTH-1:0] TOK_B = {8{32'h988b6a57}};
    localparam logic [WIDTH-1:0] TOK_C = {8{32'h5a5a0f0f}};

    lc_transition_ctrl #(.WIDTH(WIDTH), .LENGTH(LENGTH), .TIMEOUT(TIMEOUT), .MAX_FAILS(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .target_state(target_state), .token_in(token_in),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdData(mem_rdData), .mem_valid(mem_valid),
        .busy(busy), .done(done), .grant(grant), .err(err), .lc_state(lc_state), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_valid  <= mem_rd_en && !withhold;
        mem_rdData <= mem[mem_addr];
    end

    // Issue one request at a negedge and record the timeline in cycles after req.
    task automatic do_req(input logic [2:0] t, input logic [WIDTH-1:0] tok);
        rd_first = -1; rd_cnt = 0; done_cyc = -1; busy1 = 0;
        addr_seen = '0; grant_seen = 1'b0; err_seen = '0;
        req = 1'b1; target_state = t; token_in = tok;
        @(negedge clk);
        req = 1'b0;
        for (int c = 1; c < 30; c++) begin
            if (c == 1) busy1 = int'(busy);
            if (mem_rd_en) begin
                rd_cnt++;
                if (rd_first < 0) begin rd_first = c; addr_seen = mem_addr; end
            end
            if (done) begin
                done_cyc = c; grant_seen = grant; err_seen = err;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req = 1'b0; withhold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({mem_rd_en, mem_addr, busy, done, grant, err, lc_state, locked} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rd=%b addr=%0d busy=%b done=%b grant=%b err=%0d lc=%0d locked=%b want all 0",
                     mem_rd_en, mem_addr, busy, done, grant, err, lc_state, locked);
        end
    endtask

    task automatic test_grant();
        do_req(3'd1, TOK_A);
        checks++;
        if (rd_first !== 1 || rd_cnt !== 1 || addr_seen !== 3'd1) begin
            failures++;
            $display("FAIL grant_read got rd_cycle=%0d rd_count=%0d addr=%0d want 1 1 1", rd_first, rd_cnt, addr_seen);
        end
        checks++;
        if (busy1 !== 1) begin
            failures++; $display("FAIL grant_busy got %0d want 1", busy1);
        end
        checks++;
        if (done_cyc !== 3 || grant_seen !== 1'b1 || err_seen !== 2'd0 || lc_state !== 3'd1) begin
            failures++;
            $display("FAIL grant_done got done=%0d grant=%b err=%0d lc=%0d want 3 1 0 1", done_cyc, grant_seen, err_seen, lc_state);
        end
    endtask

    task automatic test_reject();
        logic [2:0] tv [2];
        tv[0] = 3'd1; tv[1] = 3'd6;
        for (int i = 0; i < 2; i++) begin
            do_req(tv[i], TOK_A);
            checks++;
            if (done_cyc !== 1 || err_seen !== 2'd1 || grant_seen !== 1'b0 || rd_cnt !== 0 || lc_state !== 3'd1) begin
                failures++;
                $display("FAIL reject_t%0d got done=%0d err=%0d grant=%b rds=%0d lc=%0d want 1 1 0 0 1",
                         tv[i], done_cyc, err_seen, grant_seen, rd_cnt, lc_state);
            end
        end
    endtask

    task automatic test_fail_clear();
        for (int i = 0; i < 2; i++) begin
            do_req(3'd2, '0);
            checks++;
            if (done_cyc !== 3 || err_seen !== 2'd2 || locked !== 1'b0) begin
                failures++;
                $display("FAIL mismatch_%0d got done=%0d err=%0d locked=%b want 3 2 0", i, done_cyc, err_seen, locked);
            end
        end
        do_req(3'd2, TOK_B);
        checks++;
        if (grant_seen !== 1'b1 || err_seen !== 2'd0 || lc_state !== 3'd2) begin
            failures++;
            $display("FAIL correct_after_fails got grant=%b err=%0d lc=%0d want 1 0 2", grant_seen, err_seen, lc_state);
        end
        for (int i = 0; i < 2; i++) begin
            do_req(3'd3, TOK_A);
            checks++;
            if (err_seen !== 2'd2 || locked !== 1'b0) begin
                failures++;
                $display("FAIL cleared_count_%0d got err=%0d locked=%b want 2 0", i, err_seen, locked);
            end
        end
    endtask

    task automatic test_timeout();
        withhold = 1'b1;
        do_req(3'd3, TOK_C);
        withhold = 1'b0;
        checks++;
        if (rd_first !== 1 || done_cyc - rd_first !== TIMEOUT + 2 || err_seen !== 2'd3 || grant_seen !== 1'b0) begin
            failures++;
            $display("FAIL timeout got rd=%0d done=%0d err=%0d grant=%b want 1 %0d 3 0",
                     rd_first, done_cyc, err_seen, grant_seen, TIMEOUT + 3);
        end
        checks++;
        if (lc_state !== 3'd2 || locked !== 1'b0) begin
            failures++; $display("FAIL timeout_state got lc=%0d locked=%b want 2 0", lc_state, locked);
        end
        // fail count must still be 2, so one more mismatch locks
        do_req(3'd3, TOK_A);
        checks++;
        if (err_seen !== 2'd2 || locked !== 1'b1) begin
            failures++; $display("FAIL timeout_kept_count got err=%0d locked=%b want 2 1", err_seen, locked);
        end
    endtask

    task automatic test_lockout();
        apply_reset();
        do_req(3'd1, TOK_A);
        for (int i = 0; i < 3; i++) begin
            do_req(3'd2, '0);
            checks++;
            if (err_seen !== 2'd2 || rd_cnt !== 1 || locked !== (i == 2)) begin
                failures++;
                $display("FAIL lock_mismatch_%0d got err=%0d rds=%0d locked=%b want 2 1 %0d", i, err_seen, rd_cnt, locked, i == 2);
            end
        end
        do_req(3'd2, TOK_B);
        checks++;
        if (done_cyc !== 1 || err_seen !== 2'd1 || rd_cnt !== 0 || lc_state !== 3'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL locked_reject got done=%0d err=%0d rds=%0d lc=%0d locked=%b want 1 1 0 1 1",
                     done_cyc, err_seen, rd_cnt, lc_state, locked);
        end
    endtask

    task automatic test_reset_mid();
        int saw_done;
        apply_reset();
        withhold = 1'b1;
        req = 1'b1; target_state = 3'd1; token_in = TOK_A;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, mem_addr, busy, done, grant, err, lc_state, locked} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got rd=%b addr=%0d busy=%b done=%b grant=%b err=%0d lc=%0d want all 0",
                     mem_rd_en, mem_addr, busy, done, grant, err, lc_state);
        end
        withhold = 1'b0;
        saw_done = 0;
        repeat (2) begin @(negedge clk); if (done) saw_done++; end
        rst_n = 1'b1;
        repeat (12) begin @(negedge clk); if (done) saw_done++; end
        checks++;
        if (saw_done !== 0) begin
            failures++; $display("FAIL mid_reset_no_done got %0d done pulses want 0", saw_done);
        end
        do_req(3'd1, TOK_A);
        checks++;
        if (done_cyc !== 3 || grant_seen !== 1'b1 || lc_state !== 3'd1) begin
            failures++;
            $display("FAIL after_mid_reset got done=%0d grant=%b lc=%0d want 3 1 1", done_cyc, grant_seen, lc_state);
        end
    endtask

    initial begin
        for (int i = 0; i < LENGTH; i++) mem[i] = '0;
        mem[1] = TOK_A;
        mem[2] = TOK_B;
        mem[3] = TOK_C;
        test_reset();
        test_grant();
        test_reject();
        test_fail_clear();
        test_timeout();
        test_lockout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
